// File: rtl/plru_pkg.sv
// Shared types and parameter-legality helpers for the pseudo-LRU replacement store.
package plru_pkg;

    typedef enum logic {
        FL_IDLE,
        FL_SWEEP
    } fl_state_t;

    localparam int MIN_SETS = 2;
    localparam int MAX_SETS = 256;
    localparam int MIN_WAYS = 2;
    localparam int MAX_WAYS = 8;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit sets_legal(input int n);
        return is_pow2(n) && (n >= MIN_SETS) && (n <= MAX_SETS);
    endfunction

    function automatic bit ways_legal(input int n);
        return is_pow2(n) && (n >= MIN_WAYS) && (n <= MAX_WAYS);
    endfunction

endpackage

// File: rtl/plru_store_if.sv
// Request/response bundle between a cache controller and the PLRU store.
interface plru_store_if #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2
) ();
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic             lookup_valid;
    logic [SET_W-1:0] lookup_set;
    logic             victim_valid;
    logic [WAY_W-1:0] victim_way;
    logic             touch_en;
    logic [SET_W-1:0] touch_set;
    logic [WAY_W-1:0] touch_way;
    logic             flush_req;
    logic             busy;

    modport master (
        output lookup_valid, lookup_set, touch_en, touch_set, touch_way, flush_req,
        input  victim_valid, victim_way, busy
    );

    modport slave (
        input  lookup_valid, lookup_set, touch_en, touch_set, touch_way, flush_req,
        output victim_valid, victim_way, busy
    );
endinterface

// File: rtl/plru_tree_logic.sv
// Combinational tree-PLRU walk (victim) and path update for one set's heap-indexed bits.
module plru_tree_logic
    import plru_pkg::*;
#(
    parameter int NUM_WAYS = 2,
    localparam int WAY_W  = $clog2(NUM_WAYS),
    localparam int NODE_W = NUM_WAYS - 1
) (
    input  logic [NODE_W-1:0] bits_in,
    input  logic [WAY_W-1:0]  way,
    output logic [WAY_W-1:0]  victim,
    output logic [NODE_W-1:0] bits_out
);

    // Heap node i lives at bits[i-1]; each step descends to 2i (bit 0) or 2i+1 (bit 1).
    always_comb begin : walk
        int node;
        victim = '0;
        node   = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            victim[WAY_W-1-lvl] = bits_in[node-1];
            node = 2 * node + int'(bits_in[node-1]);
        end
    end

    // Each node on the path is pointed away from the touched way.
    always_comb begin : update
        int   node;
        logic dir;
        bits_out = bits_in;
        node     = 1;
        dir      = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir                = way[WAY_W-1-lvl];
            bits_out[node-1]   = ~dir;
            node               = 2 * node + int'(dir);
        end
    end

endmodule

// File: rtl/plru_store.sv
// Per-set tree-PLRU state with one-cycle victim lookup, MRU touch and a sequential flush sweep.
module plru_store
    import plru_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2
) (
    input  logic         clk,
    input  logic         rst,
    plru_store_if.slave  bus
);

    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int NODE_W = NUM_WAYS - 1;
    localparam logic [SET_W:0] LAST_SET = (SET_W + 1)'(NUM_SETS - 1);

    generate
        if (!sets_legal(NUM_SETS)) begin : g_bad_sets
            $error("plru_store: NUM_SETS must be a power of two in 2..256");
        end
        if (!ways_legal(NUM_WAYS)) begin : g_bad_ways
            $error("plru_store: NUM_WAYS must be a power of two in 2..8");
        end
    endgenerate

    fl_state_t        state;
    logic [SET_W:0]   sweep_cnt;
    logic             busy_q;
    logic             victim_valid_q;
    logic [WAY_W-1:0] victim_way_q;

    logic [NODE_W-1:0] tree [NUM_SETS];

    logic              idle_accept;
    logic              touch_fire;
    logic              lookup_ok;
    logic [NODE_W-1:0] touch_cur;
    logic [NODE_W-1:0] touch_upd;
    logic [NODE_W-1:0] lookup_cur;
    logic [NODE_W-1:0] lookup_upd_unused;
    logic [WAY_W-1:0]  lookup_victim;
    logic [WAY_W-1:0]  touch_victim_unused;

    // A flush request in IDLE pre-empts any touch or lookup issued alongside it.
    assign idle_accept = (state == FL_IDLE) && !bus.flush_req;
    assign touch_fire  = idle_accept && bus.touch_en;
    assign lookup_ok   = idle_accept && bus.lookup_valid;

    assign touch_cur  = tree[bus.touch_set];
    assign lookup_cur = (touch_fire && (bus.touch_set == bus.lookup_set))
                        ? touch_upd : tree[bus.lookup_set];

    plru_tree_logic #(.NUM_WAYS(NUM_WAYS)) u_touch (
        .bits_in  (touch_cur),
        .way      (bus.touch_way),
        .victim   (touch_victim_unused),
        .bits_out (touch_upd)
    );

    plru_tree_logic #(.NUM_WAYS(NUM_WAYS)) u_lookup (
        .bits_in  (lookup_cur),
        .way      ('0),
        .victim   (lookup_victim),
        .bits_out (lookup_upd_unused)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= FL_IDLE;
            sweep_cnt      <= '0;
            busy_q         <= 1'b0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                tree[s] <= '0;
            end
        end else begin
            victim_valid_q <= lookup_ok;
            if (lookup_ok) begin
                victim_way_q <= lookup_victim;
            end
            case (state)
                FL_IDLE: begin
                    if (bus.flush_req) begin
                        state     <= FL_SWEEP;
                        sweep_cnt <= '0;
                        busy_q    <= 1'b1;
                    end else if (touch_fire) begin
                        tree[bus.touch_set] <= touch_upd;
                    end
                end
                FL_SWEEP: begin
                    tree[sweep_cnt[SET_W-1:0]] <= '0;
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == LAST_SET) begin
                        state  <= FL_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= FL_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_way   = victim_way_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_plru_store.sv
// Directed bench for plru_store: a 2-way and a 4-way instance on a shared clock.
module tb_plru_store;

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    plru_store_if #(.NUM_SETS(16), .NUM_WAYS(2)) b2 ();
    plru_store_if #(.NUM_SETS(16), .NUM_WAYS(4)) b4 ();

    plru_store #(.NUM_SETS(16), .NUM_WAYS(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    plru_store #(.NUM_SETS(16), .NUM_WAYS(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic touch2(input int s, input int w);
        b2.touch_en = 1'b1; b2.touch_set = 4'(s); b2.touch_way = 1'(w);
        step();
        b2.touch_en = 1'b0;
    endtask

    task automatic look2(input string tag, input int s, input int exp);
        b2.lookup_valid = 1'b1; b2.lookup_set = 4'(s);
        step();
        b2.lookup_valid = 1'b0;
        check({tag, "_vld"}, b2.victim_valid, 1);
        check(tag, b2.victim_way, exp);
    endtask

    task automatic touch4(input int s, input int w);
        b4.touch_en = 1'b1; b4.touch_set = 4'(s); b4.touch_way = 2'(w);
        step();
        b4.touch_en = 1'b0;
    endtask

    task automatic look4(input string tag, input int s, input int exp);
        b4.lookup_valid = 1'b1; b4.lookup_set = 4'(s);
        step();
        b4.lookup_valid = 1'b0;
        check(tag, b4.victim_way, exp);
    endtask

    task automatic flush2();
        b2.flush_req = 1'b1;
        step();
        b2.flush_req = 1'b0;
    endtask

    task automatic wait_idle2(input string tag);
        int n = 0;
        while (b2.busy && n < 100) begin
            step();
            n++;
        end
        check(tag, b2.busy, 0);
    endtask

    task automatic all_zero2(input string tag);
        for (int s = 0; s < 16; s++) begin
            b2.lookup_valid = 1'b1; b2.lookup_set = 4'(s);
            step();
            check($sformatf("%s_set%0d", tag, s), b2.victim_way, 0);
        end
        b2.lookup_valid = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        rst = 1'b0;
        b2.lookup_valid = 0; b2.lookup_set = '0; b2.touch_en = 0; b2.touch_set = '0;
        b2.touch_way = '0; b2.flush_req = 0;
        b4.lookup_valid = 0; b4.lookup_set = '0; b4.touch_en = 0; b4.touch_set = '0;
        b4.touch_way = '0; b4.flush_req = 0;

        repeat (3) step();
        check("rst_busy", b2.busy, 0);
        check("rst_vld", b2.victim_valid, 0);
        check("rst_way", b2.victim_way, 0);
        rst = 1'b1;
        step();

        all_zero2("post_rst");
        step();
        check("idle_vld", b2.victim_valid, 0);

        // 2-way behaves as true LRU
        touch2(5, 0);
        look2("s5_after_w0", 5, 1);
        look2("s4_untouched", 4, 0);
        touch2(5, 1);
        look2("s5_after_w1", 5, 0);

        // Same-cycle touch and lookup: forwarded on the same set, independent otherwise
        b2.touch_en = 1; b2.touch_set = 4'd7; b2.touch_way = 1'b0;
        b2.lookup_valid = 1; b2.lookup_set = 4'd7;
        step();
        b2.touch_en = 0; b2.lookup_valid = 0;
        check("fwd_s7", b2.victim_way, 1);
        b2.touch_en = 1; b2.touch_set = 4'd9; b2.touch_way = 1'b0;
        b2.lookup_valid = 1; b2.lookup_set = 4'd8;
        step();
        b2.touch_en = 0; b2.lookup_valid = 0;
        check("indep_s8", b2.victim_way, 0);
        look2("indep_s9", 9, 1);

        // 4-way on set 3: bits (b1,b2,b3) go 110, 100, 001, 000
        touch4(3, 0); look4("w4_t0", 3, 2);
        touch4(3, 1); look4("w4_t1", 3, 2);
        touch4(3, 2); look4("w4_t2", 3, 0);
        touch4(3, 3); look4("w4_t3", 3, 0);
        touch4(6, 3); look4("w4_s6_t3", 6, 0);
        touch4(6, 0); look4("w4_s6_t0", 6, 2);

        // Dirty every set, then sweep; touch and lookup during busy must be ignored
        for (int s = 0; s < 16; s++) touch2(s, 0);
        look2("dirty_s12", 12, 1);
        flush2();
        busy_cycles = 0;
        while (b2.busy && busy_cycles < 100) begin
            busy_cycles++;
            if (busy_cycles == 3) begin
                b2.touch_en = 1; b2.touch_set = 4'd0; b2.touch_way = 1'b0;
                b2.lookup_valid = 1; b2.lookup_set = 4'd0;
                step();
                b2.touch_en = 0; b2.lookup_valid = 0;
                check("busy_no_vld", b2.victim_valid, 0);
            end else begin
                step();
            end
        end
        check("busy_len", busy_cycles, 16);
        all_zero2("post_flush");

        // Flush wins over a simultaneous touch and lookup
        b2.flush_req = 1; b2.touch_en = 1; b2.touch_set = 4'd2; b2.touch_way = 1'b0;
        b2.lookup_valid = 1; b2.lookup_set = 4'd2;
        step();
        b2.flush_req = 0; b2.touch_en = 0; b2.lookup_valid = 0;
        check("flush_win_vld", b2.victim_valid, 0);
        check("flush_win_busy", b2.busy, 1);
        wait_idle2("flush_win_idle");
        look2("flush_win_s2", 2, 0);

        // Reset in the middle of a sweep
        touch2(1, 0);
        touch2(14, 0);
        flush2();
        repeat (5) step();
        rst = 1'b0;
        #1;
        check("mid_rst_busy", b2.busy, 0);
        check("mid_rst_vld", b2.victim_valid, 0);
        check("mid_rst_way", b2.victim_way, 0);
        step();
        rst = 1'b1;
        step();
        all_zero2("post_mid_rst");
        b2.lookup_valid = 0;
        flush2();
        check("reflush_busy", b2.busy, 1);
        wait_idle2("reflush_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
